// File: rtl/key_entry.sv
// Keypad entry buffer: debounces a key-present strobe and edits a BCD digit buffer.
// Enter hands the current entry to the submit outputs and empties the buffer.
module key_entry #(
   parameter int MAX_DIGITS     = 8,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    strobe,
   input  logic [4:0]              code,
   output logic [4*MAX_DIGITS-1:0] digits,
   output logic [3:0]              count,
   output logic                    key_valid,
   output logic                    submit,
   output logic [4*MAX_DIGITS-1:0] submit_digits,
   output logic [3:0]              submit_count,
   output logic                    err
);

   localparam int W  = 4 * MAX_DIGITS;
   localparam int CW = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(RELEASE_CYCLES - 1);
   localparam logic [3:0]    MAXC = 4'(MAX_DIGITS);

   typedef enum logic [1:0] {ARMED, HELD, DEBOUNCE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] counter_q, counter_d;
   logic [W-1:0]  digits_q, digits_d;
   logic [3:0]    count_q, count_d;
   logic [W-1:0]  submitDigits_q, submitDigits_d;
   logic [3:0]    submitCount_q, submitCount_d;
   logic          keyValid_q, keyValid_d;
   logic          submit_q, submit_d;
   logic          err_q, err_d;

   // Entering DEBOUNCE already accounts for the first low cycle, so ARMED is
   // reached after exactly RELEASE_CYCLES consecutive low cycles.
   always_comb begin
      state_d        = state_q;
      counter_d      = counter_q;
      digits_d       = digits_q;
      count_d        = count_q;
      submitDigits_d = submitDigits_q;
      submitCount_d  = submitCount_q;
      keyValid_d     = 1'b0;
      submit_d       = 1'b0;
      err_d          = 1'b0;

      case (state_q)
         ARMED: begin
            if (strobe) begin
               state_d    = HELD;
               keyValid_d = 1'b1;
               if (code < 5'd10) begin
                  if (count_q < MAXC) begin
                     digits_d = (digits_q << 4) | W'(code[3:0]);
                     count_d  = count_q + 4'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  case (code)
                     5'd16: begin
                        if (count_q != 4'd0) begin
                           digits_d = digits_q >> 4;
                           count_d  = count_q - 4'd1;
                        end
                     end
                     5'd17: begin
                        if (count_q != 4'd0) begin
                           submitDigits_d = digits_q;
                           submitCount_d  = count_q;
                           submit_d       = 1'b1;
                           digits_d       = '0;
                           count_d        = 4'd0;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     5'd18: begin
                        digits_d = '0;
                        count_d  = 4'd0;
                     end
                     default: begin
                     end
                  endcase
               end
            end
         end
         HELD: begin
            if (!strobe) begin
               counter_d = '0;
               state_d   = (RELEASE_CYCLES == 1) ? ARMED : DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (strobe) begin
               state_d = HELD;
            end else if (counter_q + CW'(1) == LAST) begin
               state_d = ARMED;
            end else begin
               counter_d = counter_q + CW'(1);
            end
         end
         default: state_d = HELD;
      endcase
   end

   // Reset parks the FSM in HELD so a key still down at release is not taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= HELD;
         counter_q      <= '0;
         digits_q       <= '0;
         count_q        <= 4'd0;
         submitDigits_q <= '0;
         submitCount_q  <= 4'd0;
         keyValid_q     <= 1'b0;
         submit_q       <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         counter_q      <= counter_d;
         digits_q       <= digits_d;
         count_q        <= count_d;
         submitDigits_q <= submitDigits_d;
         submitCount_q  <= submitCount_d;
         keyValid_q     <= keyValid_d;
         submit_q       <= submit_d;
         err_q          <= err_d;
      end
   end

   assign digits        = digits_q;
   assign count         = count_q;
   assign key_valid     = keyValid_q;
   assign submit        = submit_q;
   assign submit_digits = submitDigits_q;
   assign submit_count  = submitCount_q;
   assign err           = err_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: directed scenarios plus randomized key traffic,
// all compared every cycle against a list-based behavioural model.
module tb_key_entry;

   localparam int MAX_DIGITS     = 8;
   localparam int RELEASE_CYCLES = 4;
   localparam int W              = 4 * MAX_DIGITS;

   logic          clk = 1'b0;
   logic          rst;
   logic          strobe;
   logic [4:0]    code;
   logic [W-1:0]  digits;
   logic [3:0]    count;
   logic          key_valid;
   logic          submit;
   logic [W-1:0]  submit_digits;
   logic [3:0]    submit_count;
   logic          err;

   int checks = 0;
   int errors = 0;

   // Model: digit list oldest-first, plus "armed" after enough low cycles
   int           mBuf[MAX_DIGITS];
   int           mN;
   logic [W-1:0] mSubDig;
   int           mSubCnt;
   bit           mKv, mSub, mErr;
   bit           mArmed;
   int           mLow;

   int kvSeen  = 0;
   int errSeen = 0;
   int subSeen = 0;

   key_entry #(.MAX_DIGITS(MAX_DIGITS), .RELEASE_CYCLES(RELEASE_CYCLES)) dut (
      .clk(clk), .rst(rst), .strobe(strobe), .code(code),
      .digits(digits), .count(count), .key_valid(key_valid), .submit(submit),
      .submit_digits(submit_digits), .submit_count(submit_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [W-1:0] modelDigits();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < mN; i++) v = (v << 4) | W'(mBuf[i]);
      return v;
   endfunction

   task automatic processKey(input int c);
      mKv = 1;
      if (c < 10) begin
         if (mN < MAX_DIGITS) begin
            mBuf[mN] = c;
            mN++;
         end else mErr = 1;
      end else if (c == 16) begin
         if (mN > 0) mN--;
      end else if (c == 17) begin
         if (mN > 0) begin
            mSubDig = modelDigits();
            mSubCnt = mN;
            mSub    = 1;
            mN      = 0;
         end else mErr = 1;
      end else if (c == 18) begin
         mN = 0;
      end
   endtask

   task automatic modelStep(input bit r, input bit s, input int c);
      mKv = 0; mSub = 0; mErr = 0;
      if (r) begin
         mN = 0; mSubDig = '0; mSubCnt = 0; mArmed = 0; mLow = 0;
      end else if (s) begin
         if (mArmed) begin
            mArmed = 0;
            processKey(c);
         end
         mLow = 0;
      end else begin
         mLow++;
         if (mLow >= RELEASE_CYCLES) mArmed = 1;
      end
   endtask

   task automatic checkAll();
      checkOutput("digits", 64'(digits), 64'(modelDigits()));
      checkOutput("count", 64'(count), 64'(mN));
      checkOutput("key_valid", 64'(key_valid), 64'(mKv));
      checkOutput("submit", 64'(submit), 64'(mSub));
      checkOutput("err", 64'(err), 64'(mErr));
      checkOutput("submit_digits", 64'(submit_digits), 64'(mSubDig));
      checkOutput("submit_count", 64'(submit_count), 64'(mSubCnt));
      kvSeen  += int'(key_valid === 1'b1);
      errSeen += int'(err === 1'b1);
      subSeen += int'(submit === 1'b1);
   endtask

   // Drives one cycle of inputs at the falling edge and checks after the rising edge
   task automatic applyStimulus(input bit r, input bit s, input int c);
      rst    = r;
      strobe = s;
      code   = 5'(c);
      modelStep(r, s, c);
      @(negedge clk);
      checkAll();
   endtask

   task automatic press(input int c, input int hi, input int lo);
      repeat (hi) applyStimulus(0, 1, c);
      repeat (lo) applyStimulus(0, 0, c);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int mark, mark2, s, len, c, sel;
      rst = 1'b1; strobe = 1'b0; code = 5'd0;
      mN = 0; mSubDig = '0; mSubCnt = 0; mArmed = 0; mLow = 0;
      @(negedge clk);

      applyStimulus(1, 0, 0);
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_digits", 64'(digits), 64'd0);
      checkOutput("reset_submit_count", 64'(submit_count), 64'd0);

      repeat (4) applyStimulus(0, 0, 0);
      press(1, 3, 5); press(2, 3, 5); press(3, 3, 5); press(4, 3, 5);
      mark = subSeen;
      press(17, 3, 5);
      checkOutput("entry_submit_pulses", 64'(subSeen - mark), 64'd1);
      checkOutput("entry_submit_digits", 64'(submit_digits[15:0]), 64'h1234);
      checkOutput("entry_submit_count", 64'(submit_count), 64'd4);
      checkOutput("entry_count_after", 64'(count), 64'd0);

      mark = errSeen;
      mark2 = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) mark2 = errSeen;
         press(9, 3, 5);
      end
      checkOutput("full_count", 64'(count), 64'd8);
      checkOutput("full_digits", 64'(digits), 64'h99999999);
      checkOutput("full_err_total", 64'(errSeen - mark), 64'd1);
      checkOutput("full_err_ninth", 64'(errSeen - mark2), 64'd1);
      press(18, 3, 5);
      checkOutput("clear_count", 64'(count), 64'd0);

      press(5, 3, 5); press(6, 3, 5); press(16, 3, 5);
      checkOutput("bksp_digits", 64'(digits), 64'h5);
      checkOutput("bksp_count", 64'(count), 64'd1);
      press(16, 3, 5);
      checkOutput("bksp_empty_count", 64'(count), 64'd0);
      mark = errSeen;
      press(16, 3, 5);
      checkOutput("bksp_zero_err", 64'(errSeen - mark), 64'd0);
      checkOutput("bksp_zero_digits", 64'(digits), 64'd0);

      mark = kvSeen;
      repeat (50) applyStimulus(0, 1, 3);
      checkOutput("hold_one_accept", 64'(kvSeen - mark), 64'd1);
      checkOutput("hold_count", 64'(count), 64'd1);
      repeat (2) applyStimulus(0, 0, 3);
      repeat (10) applyStimulus(0, 1, 3);
      checkOutput("glitch_no_accept", 64'(kvSeen - mark), 64'd1);
      repeat (5) applyStimulus(0, 0, 3);

      press(18, 3, 5);
      mark = errSeen; mark2 = subSeen;
      press(17, 3, 5);
      checkOutput("enter_empty_err", 64'(errSeen - mark), 64'd1);
      checkOutput("enter_empty_submit", 64'(subSeen - mark2), 64'd0);
      checkOutput("enter_empty_keep", 64'(submit_digits[15:0]), 64'h1234);
      mark = kvSeen;
      press(12, 3, 5);
      checkOutput("ignored_kv", 64'(kvSeen - mark), 64'd1);
      checkOutput("ignored_count", 64'(count), 64'd0);

      press(8, 3, 5);
      mark = kvSeen;
      applyStimulus(1, 1, 7);
      checkOutput("rst_accept_count", 64'(count), 64'd0);
      checkOutput("rst_accept_kv", 64'(key_valid), 64'd0);
      checkOutput("rst_accept_subdig", 64'(submit_digits), 64'd0);
      repeat (5) applyStimulus(0, 1, 7);
      repeat (RELEASE_CYCLES - 1) applyStimulus(0, 0, 7);
      repeat (2) applyStimulus(0, 1, 7);
      checkOutput("rst_hold_no_accept", 64'(kvSeen - mark), 64'd0);
      repeat (RELEASE_CYCLES) applyStimulus(0, 0, 7);
      press(7, 3, 5);
      checkOutput("rst_release_accept", 64'(kvSeen - mark), 64'd1);
      checkOutput("rst_release_count", 64'(count), 64'd1);

      for (int it = 0; it < 700; it++) begin
         s   = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 7));
         sel = int'($urandom_range(0, 9));
         if (sel <= 5)      c = int'($urandom_range(0, 9));
         else if (sel == 6) c = 16;
         else if (sel == 7) c = 17;
         else if (sel == 8) c = 18;
         else               c = int'($urandom_range(10, 31));
         for (int k = 0; k < len; k++) begin
            applyStimulus(($urandom_range(0, 199) == 0), s[0], c);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
